sdec_sched: RTL and testbench
=============================

SDEC_SCHED -- requirements
Module: sdec_sched

Interface
REQ-001 Parameter DATAWIDTH, default 8, SHALL set the width of all signed data ports.
REQ-002 Parameter STEPW, default 4, SHALL set the width of the unsigned step-count ports.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 Req0, Req1  input  1 each  SHALL be requester n's job request, held high until Ackn.
REQ-006 Val0, Val1  input  signed DATAWIDTH each  SHALL be requester n's start value, sampled at capture.
REQ-007 Steps0, Steps1  input  STEPW each  SHALL be requester n's decrement count, sampled at capture.
REQ-008 Ack0, Ack1  output  1 each  SHALL pulse for one cycle when requester n's job is accepted.
REQ-009 Done0, Done1  output  1 each  SHALL pulse for one cycle when requester n's job completes.
REQ-010 Result  output  signed DATAWIDTH  SHALL carry the job result, valid only while a Donen is high.
REQ-011 Ovf  output  1  SHALL flag a two's-complement wrap in the job, valid only while a Donen is high.
REQ-012 Busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, RUN and DONE; no other states are reachable.
REQ-014 In IDLE with any Reqn high, the next edge (capture edge t0) SHALL select the winner, load acc=Val, cnt=Steps and Ovf=0, record the grant index, and enter RUN.
REQ-015 Arbitration SHALL be round-robin: if both Req are high, the requester not granted last wins; the last-grant pointer resets to 1, so requester 0 wins first.
REQ-016 Ackn SHALL be high for exactly the cycle following t0; a Req dropped before capture SHALL be ignored without error.
REQ-017 In RUN, when cnt!=0, each edge SHALL set acc=acc-1 through the shared decrementer and cnt=cnt-1.
REQ-018 In RUN, when cnt==0, the edge SHALL leave acc unchanged and enter DONE.
REQ-019 Donen SHALL be high for exactly the cycle beginning at edge t0+Steps+1; Steps=0 gives Done at t0+1 with Result=Val.
REQ-020 Decrement arithmetic SHALL wrap in two's complement; a decrement from -2^(DATAWIDTH-1) SHALL set Ovf, which stays set until the next capture.
REQ-021 DONE SHALL return to IDLE on the next edge; requests are not captured in DONE or RUN.
REQ-022 Req changes, and Val or Steps changes after capture, SHALL have no effect on a job in flight.
REQ-023 While Done is low, Result SHALL be don't-care; the bench checks it only under Done.

Reset
REQ-024 Rst low SHALL immediately force IDLE, acc=0, cnt=0, Ovf=0, last-grant=1, and all Ack, Done and Busy outputs low.
REQ-025 Reset mid-RUN or mid-DONE SHALL abort the job with no Done pulse; the first capture after release behaves as from power-up.

Structure
REQ-026 A shared package/header sdec_sched_pkg SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the grant-index constants.
REQ-027 The decrement SHALL be done by exactly one SDEC sub-module instance (DATAWIDTH passed through), fed by acc; no second subtractor.
REQ-028 The FSM, arbiter and counter SHALL live in sdec_sched; no other sub-modules.

Verification
REQ-029 Req0=1, Val0=5, Steps0=3 -> Ack0 at t0+1, Done0 at t0+4, Result=2, Ovf=0.
REQ-030 Req1=1, Val1=-127, Steps1=3 -> Done1 at t0+4, Result=126, Ovf=1 (wrap via -128 to 127).
REQ-031 Req0 and Req1 high together after reset (Val0=10, Steps0=1; Val1=20, Steps1=2) -> job 0 first (Result=9), then job 1 (Result=18).
REQ-032 Steps0=0, Val0=-3 -> Done0 at t0+1, Result=-3, Ovf=0.
REQ-033 Rst low two cycles into a Steps=8 job -> Busy=0 at once, no Done pulse; a new Val0=1, Steps0=1 job then gives Result=0.

Source files
------------

// File: rtl/sdec_sched_pkg.sv
// Shared encodings for the sdec_sched job scheduler: FSM states, grant indices
// and the round-robin pick used when both requesters are waiting.
package sdec_sched_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic GNT_0 = 1'b0;
    localparam logic GNT_1 = 1'b1;

    // With both requests up the one not served last wins; otherwise the lone requester wins.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last_grant);
        logic pick;
        if (req0 && req1) begin
            pick = (last_grant == GNT_0) ? GNT_1 : GNT_0;
        end else if (req1) begin
            pick = GNT_1;
        end else begin
            pick = GNT_0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/sdec_sched_sdec.sv
// Signed decrement-by-one with a flag marking the two's-complement wrap from
// the most negative value.
module sdec_sched_sdec #(
    parameter int DATAWIDTH = 8
) (
    input  logic signed [DATAWIDTH-1:0] a,
    output logic signed [DATAWIDTH-1:0] y,
    output logic                        wrap
);

    localparam logic signed [DATAWIDTH-1:0] ONE  = DATAWIDTH'(1);
    localparam logic signed [DATAWIDTH-1:0] MINV = {1'b1, {(DATAWIDTH-1){1'b0}}};

    assign y    = a - ONE;
    assign wrap = (a == MINV);

endmodule

// File: rtl/sdec_sched.sv
// Two-requester job scheduler: round-robin capture, count-down decrement of the
// start value through one shared decrementer, single-cycle ack/done pulses.
//
// state   | meaning
// IDLE    | waiting for a request; captures winner on the next edge
// RUN     | decrementing acc once per edge until cnt reaches zero
// DONE    | result and ovf presented with the winner's done pulse
module sdec_sched
    import sdec_sched_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int STEPW     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req0,
    input  logic                        req1,
    input  logic signed [DATAWIDTH-1:0] val0,
    input  logic signed [DATAWIDTH-1:0] val1,
    input  logic        [STEPW-1:0]     steps0,
    input  logic        [STEPW-1:0]     steps1,
    output logic                        ack0,
    output logic                        ack1,
    output logic                        done0,
    output logic                        done1,
    output logic signed [DATAWIDTH-1:0] result,
    output logic                        ovf,
    output logic                        busy
);

    logic [1:0]                  state;
    logic signed [DATAWIDTH-1:0] acc;
    logic [STEPW-1:0]            cnt;
    logic                        ovf_q;
    logic                        grant;
    logic                        last_grant;
    logic                        ack0_q;
    logic                        ack1_q;

    logic                        pick;
    logic signed [DATAWIDTH-1:0] dec_y;
    logic                        dec_wrap;

    assign pick = rr_pick(req0, req1, last_grant);

    sdec_sched_sdec #(
        .DATAWIDTH(DATAWIDTH)
    ) u_sdec (
        .a    (acc),
        .y    (dec_y),
        .wrap (dec_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            acc        <= '0;
            cnt        <= '0;
            ovf_q      <= 1'b0;
            grant      <= GNT_0;
            last_grant <= GNT_1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        grant      <= pick;
                        last_grant <= pick;
                        acc        <= (pick == GNT_1) ? val1 : val0;
                        cnt        <= (pick == GNT_1) ? steps1 : steps0;
                        ovf_q      <= 1'b0;
                        ack0_q     <= (pick == GNT_0);
                        ack1_q     <= (pick == GNT_1);
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt != '0) begin
                        acc <= dec_y;
                        cnt <= cnt - STEPW'(1);
                        // ovf is sticky until the next capture
                        if (dec_wrap) begin
                            ovf_q <= 1'b1;
                        end
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign done0  = (state == ST_DONE) && (grant == GNT_0);
    assign done1  = (state == ST_DONE) && (grant == GNT_1);
    assign result = acc;
    assign ovf    = ovf_q;
    assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_sdec_sched.sv
// Self-checking bench for sdec_sched: directed scenarios plus randomized jobs
// checked against an arithmetic model of result, overflow, timing and arbitration.
module tb_sdec_sched;

    logic              clk;
    logic              rst_n;
    logic              req0, req1;
    logic signed [7:0] val0, val1;
    logic        [3:0] steps0, steps1;
    logic              ack0, ack1, done0, done1, ovf, busy;
    logic signed [7:0] result;

    int total = 0;
    int bad   = 0;
    bit last  = 1'b1;

    sdec_sched #(.DATAWIDTH(8), .STEPW(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .req1   (req1),
        .val0   (val0),
        .val1   (val1),
        .steps0 (steps0),
        .steps1 (steps1),
        .ack0   (ack0),
        .ack1   (ack1),
        .done0  (done0),
        .done1  (done1),
        .result (result),
        .ovf    (ovf),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic scramble_inputs();
        val0   = 8'($urandom);
        val1   = 8'($urandom);
        steps0 = 4'($urandom_range(0, 15));
        steps1 = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) req0 = ~req0;
        if ($urandom_range(0, 3) == 0) req1 = ~req1;
    endtask

    // Called at a negedge with the DUT idle and at least one request high.
    task automatic serve(input bit scramble);
        bit w;
        int v, s, res;
        logic signed [7:0] er;
        bit eo;
        if (req0 && req1) w = ~last;
        else w = req1;
        v = w ? int'(val1) : int'(val0);
        s = w ? int'(steps1) : int'(steps0);
        last = w;
        res = v - s;
        er = res[7:0];
        eo = (res < -128);
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({ack0, ack1, busy, done0, done1} !== {~w, w, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL ack_cycle: got %b want %b", {ack0, ack1, busy, done0, done1}, {~w, w, 1'b1, 2'b00});
        end
        if (w) req1 = 1'b0;
        else req0 = 1'b0;
        for (int n = 1; n <= s; n++) begin
            if (scramble) scramble_inputs();
            @(negedge clk);
            total++;
            if ({ack0, ack1, busy, done0, done1} !== 5'b00100) begin
                bad++;
                $display("FAIL run_cycle %0d: got %b want 00100", n, {ack0, ack1, busy, done0, done1});
            end
        end
        if (scramble) scramble_inputs();
        @(negedge clk);
        total++;
        if ({ack0, ack1, busy, done0, done1} !== {3'b001, ~w, w}) begin
            bad++;
            $display("FAIL done_pulse: got %b want %b", {ack0, ack1, busy, done0, done1}, {3'b001, ~w, w});
        end
        total++;
        if (result !== er) begin
            bad++;
            $display("FAIL result: got %0d want %0d (val=%0d steps=%0d)", result, er, v, s);
        end
        total++;
        if (ovf !== eo) begin
            bad++;
            $display("FAIL ovf: got %b want %b (val=%0d steps=%0d)", ovf, eo, v, s);
        end
        @(negedge clk);
        total++;
        if ({ack0, ack1, busy, done0, done1} !== 5'b00000) begin
            bad++;
            $display("FAIL back_to_idle: got %b want 00000", {ack0, ack1, busy, done0, done1});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0; val0 = 0; val1 = 0; steps0 = 0; steps1 = 0;
        last = 1'b1;
        #12;
        total++;
        if ({ack0, ack1, busy, done0, done1, ovf} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 000000", {ack0, ack1, busy, done0, done1, ovf});
        end
        total++;
        if (result !== 8'sd0) begin
            bad++;
            $display("FAIL reset_result: got %0d want 0", result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({ack0, ack1, busy, done0, done1} !== 5'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got %b want 00000", {ack0, ack1, busy, done0, done1});
        end
    endtask

    task automatic test_basic();
        req0 = 1; val0 = 8'sd5; steps0 = 4'd3;
        serve(1'b0);
    endtask

    task automatic test_wrap();
        req1 = 1; val1 = -8'sd127; steps1 = 4'd3;
        serve(1'b0);
    endtask

    task automatic test_zero_steps();
        req0 = 1; val0 = -8'sd3; steps0 = 4'd0;
        serve(1'b0);
    endtask

    task automatic test_dropped_req();
        req0 = 1;
        #2;
        req0 = 0;
        @(negedge clk);
        total++;
        if ({ack0, ack1, busy, done0, done1} !== 5'b0) begin
            bad++;
            $display("FAIL dropped_req: got %b want 00000", {ack0, ack1, busy, done0, done1});
        end
    endtask

    task automatic test_arbitration();
        rst_n = 1'b0;
        last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req0 = 1; val0 = 8'sd10; steps0 = 4'd1;
        req1 = 1; val1 = 8'sd20; steps1 = 4'd2;
        serve(1'b0);
        serve(1'b0);
    endtask

    task automatic test_abort();
        req0 = 1; val0 = 8'($urandom); steps0 = 4'd8;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({ack0, busy} !== 2'b11) begin
            bad++;
            $display("FAIL abort_ack: got %b want 11", {ack0, busy});
        end
        req0 = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        last = 1'b1;
        #1;
        total++;
        if ({ack0, ack1, busy, done0, done1} !== 5'b0) begin
            bad++;
            $display("FAIL abort_immediate: got %b want 00000", {ack0, ack1, busy, done0, done1});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if ({ack0, ack1, busy, done0, done1} !== 5'b0) begin
                bad++;
                $display("FAIL abort_no_done %0d: got %b want 00000", i, {ack0, ack1, busy, done0, done1});
            end
        end
        req0 = 1; val0 = 8'sd1; steps0 = 4'd1;
        req1 = 1; val1 = 8'($urandom); steps1 = 4'($urandom_range(0, 15));
        serve(1'b0);
        serve(1'b0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 60; j++) begin
            if (!req0 && !req1) begin
                int r;
                r = $urandom_range(1, 3);
                req0 = r[0];
                req1 = r[1];
                val0 = 8'($urandom);
                val1 = 8'($urandom);
                steps0 = 4'($urandom_range(0, 15));
                steps1 = 4'($urandom_range(0, 15));
            end
            serve(1'b1);
        end
        req0 = 0;
        req1 = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_steps();
        test_dropped_req();
        test_arbitration();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
